// File: rtl/gated_accumulator_pkg.sv
// Shared definitions for the gated accumulator slice.
// Holds FSM encoding and default widths matched to the gating mux.
package gated_accumulator_pkg;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/gated_accumulator_sat_detect_add.sv
// Combinational signed adder: sign-extends operand to accumulator width.
// Ports: acc_i, op_i in; sum_o (wrapping sum), ovf_o (signed overflow) out.
module sat_detect_add #(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 32
) (
   input  logic [ACC_WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]     op_i,
   output logic [ACC_WIDTH-1:0] sum_o,
   output logic                 ovf_o
);

   logic [ACC_WIDTH-1:0] op_ext;

   assign op_ext = ACC_WIDTH'($signed(op_i));
   assign sum_o  = acc_i + op_ext;

   // same-sign addends whose result flips sign have wrapped
   assign ovf_o = (acc_i[ACC_WIDTH-1] == op_ext[ACC_WIDTH-1]) &&
                  (sum_o[ACC_WIDTH-1] != acc_i[ACC_WIDTH-1]);

endmodule

// File: rtl/gated_accumulator.sv
// Accumulates a programmed number of gated operands into one signed sum.
// Ports: start/len begin a burst, in_* operand stream, out_* result, busy.
module gated_accumulator
   import gated_accumulator_pkg::*;
#(
   parameter int WIDTH     = DATA_W,
   parameter int ACC_WIDTH = ACC_W,
   parameter int CNT_WIDTH = CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] len,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_ovf,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);

   state_e               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;
   logic                 ovf_q, ovf_d;
   logic [ACC_WIDTH-1:0] add_sum;
   logic                 add_ovf;
   logic                 accept;

   sat_detect_add #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_add (
      .acc_i (acc_q),
      .op_i  (in_data),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = (len == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            if (accept && rem_q == CNT_WIDTH'(1)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      rem_d = rem_q;
      ovf_d = ovf_q;
      if (state_q == IDLE && start) begin
         acc_d = '0;
         ovf_d = 1'b0;
         rem_d = len;
      end else if (accept) begin
         acc_d = add_sum;
         ovf_d = ovf_q | add_ovf;
         rem_d = rem_q - CNT_WIDTH'(1);
      end
   end

   always_comb begin
      in_ready  = (state_q == ACCUM);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   // result registers are the accumulator itself; held until next start
   assign out_sum = acc_q;
   assign out_ovf = ovf_q;

endmodule

// File: tb/tb_gated_accumulator.sv
// Directed bench for gated_accumulator with a result scoreboard.
// Uses a 32-bit and a 16-bit accumulator instance sharing clk/rst.
module tb_gated_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        start;
   logic [7:0]  len;
   logic [15:0] in_data;
   logic        in_valid;
   logic        out_ready;

   logic        a_in_ready, a_ovf, a_valid, a_busy;
   logic [31:0] a_sum;
   logic        b_in_ready, b_ovf, b_valid, b_busy;
   logic [15:0] b_sum;

   logic        o_in_ready, o_ovf, o_valid, o_busy;
   logic [31:0] o_sum;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] sum;
      logic        ovf;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   gated_accumulator u_a (
      .clk       (clk),
      .rst       (rst),
      .start     (start & ~sel),
      .len       (len),
      .in_data   (in_data),
      .in_valid  (in_valid & ~sel),
      .in_ready  (a_in_ready),
      .out_sum   (a_sum),
      .out_ovf   (a_ovf),
      .out_valid (a_valid),
      .out_ready (out_ready & ~sel),
      .busy      (a_busy)
   );

   gated_accumulator #(.ACC_WIDTH(16)) u_b (
      .clk       (clk),
      .rst       (rst),
      .start     (start & sel),
      .len       (len),
      .in_data   (in_data),
      .in_valid  (in_valid & sel),
      .in_ready  (b_in_ready),
      .out_sum   (b_sum),
      .out_ovf   (b_ovf),
      .out_valid (b_valid),
      .out_ready (out_ready & sel),
      .busy      (b_busy)
   );

   always_comb begin
      o_in_ready = sel ? b_in_ready : a_in_ready;
      o_ovf      = sel ? b_ovf : a_ovf;
      o_valid    = sel ? b_valid : a_valid;
      o_busy     = sel ? b_busy : a_busy;
      o_sum      = sel ? {16'h0, b_sum} : a_sum;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_start(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input logic [15:0] d);
      bit done = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 20 && !done; i++) begin
         if (o_in_ready) done = 1;
         tick();
      end
      in_valid = 1'b0;
      chk("feed_accepted", 32'(done), 32'd1);
   endtask

   task automatic push(input logic [31:0] s, input logic o);
      exp_t e;
      e.sum = s;
      e.ovf = o;
      sb.push_back(e);
   endtask

   task automatic collect(input int hold);
      exp_t e;
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (o_valid) seen = 1;
         else tick();
      end
      chk("out_valid_seen", 32'(seen), 32'd1);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("sum", o_sum, e.sum);
         chk("ovf", 32'(o_ovf), 32'(e.ovf));
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_sum", o_sum, e.sum);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_drop", 32'(o_valid), 32'd0);
      chk("busy_drop", 32'(o_busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; start = 1'b0; len = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_sum", o_sum, 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(o_in_ready), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_ovf", 32'(o_ovf), 32'd0);
      rst = 1'b0;
      tick();

      // basic burst with a gated zero
      do_start(8'd4);
      chk("basic_ready", 32'(o_in_ready), 32'd1);
      chk("basic_busy", 32'(o_busy), 32'd1);
      push(32'd12, 1'b0);
      feed(16'd3); feed(16'hFFFF); feed(16'd0); feed(16'd10);
      chk("latency", 32'(o_valid), 32'd1);
      chk("done_ready", 32'(o_in_ready), 32'd0);
      collect(5);

      // input stalls between elements
      do_start(8'd3);
      push(32'd3, 1'b0);
      feed(16'h0001); tick();
      chk("stall_busy", 32'(o_busy), 32'd1);
      feed(16'h0001); tick();
      feed(16'h0001);
      collect(1);

      // empty burst
      do_start(8'd0);
      chk("empty_ready", 32'(o_in_ready), 32'd0);
      push(32'd0, 1'b0);
      collect(0);

      // 16-bit accumulator overflow, then clean burst
      sel = 1'b1;
      tick();
      do_start(8'd2);
      push(32'h8000, 1'b1);
      feed(16'h7FFF); feed(16'h0001);
      collect(0);
      do_start(8'd1);
      push(32'd5, 1'b0);
      feed(16'd5);
      collect(0);
      sel = 1'b0;
      tick();

      // start ignored in ACCUM and in the DONE handshake cycle
      do_start(8'd2);
      feed(16'd4);
      start = 1'b1; len = 8'd9;
      tick();
      start = 1'b0;
      feed(16'd6);
      chk("ign_valid", 32'(o_valid), 32'd1);
      chk("ign_sum", o_sum, 32'd10);
      out_ready = 1'b1; start = 1'b1; len = 8'd1;
      tick();
      out_ready = 1'b0; start = 1'b0;
      chk("ign_hs_busy", 32'(o_busy), 32'd0);
      chk("ign_hs_sum", o_sum, 32'd10);
      tick();
      chk("ign_idle", 32'(o_busy), 32'd0);

      // reset mid-burst
      do_start(8'd4);
      feed(16'd100); feed(16'd200);
      rst = 1'b1;
      #1;
      chk("mrst_sum", o_sum, 32'd0);
      chk("mrst_valid", 32'(o_valid), 32'd0);
      chk("mrst_busy", 32'(o_busy), 32'd0);
      chk("mrst_ready", 32'(o_in_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      do_start(8'd1);
      push(32'hFFFFFFF9, 1'b0);
      feed(16'hFFF9);
      collect(0);

      // maximum-length burst
      do_start(8'd255);
      push(32'd255, 1'b0);
      for (int i = 0; i < 254; i++) feed(16'd1);
      chk("max_busy", 32'(o_busy), 32'd1);
      chk("max_not_done", 32'(o_valid), 32'd0);
      feed(16'd1);
      collect(0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
